// File: rtl/latch_en_gen.sv
// rtl/latch_en_gen.sv - registered setup/open/hold enable sequencer for a level-sensitive latch
module latch_en_gen #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int OPEN_CYC  = 3,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic             busy_out,
  output logic             ack_out,
  output logic             drop_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // A request ignored at one edge is reported one edge later.
  logic             drop_pend;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      cnt       <= '0;
      d_out     <= '0;
      en_out    <= 1'b0;
      busy_out  <= 1'b0;
      ack_out   <= 1'b0;
      drop_out  <= 1'b0;
      drop_pend <= 1'b0;
    end else begin
      ack_out   <= 1'b0;
      drop_out  <= drop_pend;
      drop_pend <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (req_in) begin
            d_out    <= data_in;
            busy_out <= 1'b1;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end else begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        SETUP: begin
          drop_pend <= req_in;
          if (cnt == '0) begin
            cnt    <= OPEN_LD;
            en_out <= 1'b1;
            state  <= OPEN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OPEN: begin
          drop_pend <= req_in;
          if (cnt == '0) begin
            cnt    <= HOLD_LD;
            en_out <= 1'b0;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          drop_pend <= req_in;
          if (cnt == '0) begin
            ack_out <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          en_out <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_en_gen.sv
// tb/tb_latch_en_gen.sv - directed vector table plus corner sequences for latch_en_gen
module tb_latch_en_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, req_f;
  logic [7:0] data, data_f;
  logic [7:0] d, d_f;
  logic       en, busy, ack, drop;
  logic       en_f, busy_f, ack_f, drop_f;

  always #5 clk = ~clk;

  latch_en_gen u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .data_in(data),
    .d_out(d), .en_out(en), .busy_out(busy), .ack_out(ack), .drop_out(drop)
  );

  latch_en_gen #(.WIDTH(8), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1), .CNT_W(4)) u_fast (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req_f), .data_in(data_f),
    .d_out(d_f), .en_out(en_f), .busy_out(busy_f), .ack_out(ack_f), .drop_out(drop_f)
  );

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic [7:0] exp_d;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_ack;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [7:0] dt, input logic [7:0] ed,
                     input logic een, input logic eb, input logic ea, input logic edr);
    vec_t v;
    v.req = r; v.data = dt; v.exp_d = ed; v.exp_en = een;
    v.exp_busy = eb; v.exp_ack = ea; v.exp_drop = edr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] last_acc, q_model, prev_d, dt;
    logic       r, seen;
    int         e, next_ok, ack_e, viol;

    rst_n = 1'b0; req = 1'b0; data = '0; req_f = 1'b0; data_f = '0;
    @(negedge clk);
    check("reset_state", {d, en, busy, ack, drop}, 12'h000);
    check("reset_state_fast", {d_f, en_f, busy_f, ack_f, drop_f}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Plain sequence with a dropped request, then a back-to-back request at DONE.
    add(1, 8'hA5, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 1, 0, 0);
    add(1, 8'h3C, 8'hA5, 1, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 1, 0, 1);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 1, 0);
    add(0, 8'h00, 8'hA5, 0, 0, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 0, 0, 0);
    add(1, 8'hA5, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 1, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 0, 0);
    add(0, 8'h00, 8'hA5, 0, 1, 1, 0);
    add(1, 8'h5A, 8'h5A, 0, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 0, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 1, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 1, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 1, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 0, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 0, 1, 0, 0);
    add(0, 8'h00, 8'h5A, 0, 1, 1, 0);
    add(0, 8'h00, 8'h5A, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; data = vecs[i].data;
      step();
      check($sformatf("vec%0d", i), {d, en, busy, ack, drop},
            {vecs[i].exp_d, vecs[i].exp_en, vecs[i].exp_busy, vecs[i].exp_ack, vecs[i].exp_drop});
    end
    req = 1'b0;

    // Asynchronous reset while the window is open.
    req = 1'b1; data = 8'h77;
    step();
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = en;
    end
    check("en_reached_before_reset", {11'h0, seen}, 12'h001);
    #1 rst_n = 1'b0;
    #1 check("async_reset_clears", {d, en, busy, ack, drop}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req = 1'b1; data = 8'hC3;
    step();
    req = 1'b0;
    check("restart_accept", {d, en, busy, ack, drop}, {8'hC3, 4'b0100});
    step();
    check("restart_setup_full", {d, en, busy, ack, drop}, {8'hC3, 4'b0100});
    step();
    check("restart_open", {d, en, busy, ack, drop}, {8'hC3, 4'b1100});
    repeat (8) step();

    // Minimum phase lengths on the second instance.
    req_f = 1'b1; data_f = 8'h96;
    step();
    req_f = 1'b0;
    check("fast_k", {d_f, en_f, busy_f, ack_f, drop_f}, {8'h96, 4'b0100});
    step();
    check("fast_k1", {d_f, en_f, busy_f, ack_f, drop_f}, {8'h96, 4'b1100});
    step();
    check("fast_k2", {d_f, en_f, busy_f, ack_f, drop_f}, {8'h96, 4'b0100});
    step();
    check("fast_k3", {d_f, en_f, busy_f, ack_f, drop_f}, {8'h96, 4'b0110});
    step();
    check("fast_k4", {d_f, en_f, busy_f, ack_f, drop_f}, {8'h96, 4'b0000});

    // Random traffic against a latch model and a bench-side acceptance schedule.
    e = 0; next_ok = 0; ack_e = -1; viol = 0;
    last_acc = d; q_model = d; prev_d = d;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 3) == 0);
      dt = 8'($urandom);
      req = r; data = dt;
      step();
      e++;
      if (r && e >= next_ok) begin
        last_acc = dt;
        next_ok  = e + 8;
        ack_e    = e + 7;
      end
      if (en && d !== prev_d) viol++;
      if (en) q_model = d;
      prev_d = d;
      check($sformatf("rand_ack_e%0d", e), {11'h0, ack}, {11'h0, (e == ack_e)});
      if (e == ack_e)
        check($sformatf("rand_q_e%0d", e), {4'h0, q_model}, {4'h0, last_acc});
    end
    req = 1'b0;
    check("rand_en_d_stable", 12'(viol), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/latch_en_gen.md
Name: latch_en_gen

Overview:
- Upstream drive stage for the level-sensitive D-latch cells (d_in/en_in interface).
- Takes a single-cycle capture request with a data word and produces a glitch-free, registered enable window for the downstream latch.
- Sequences the window as setup, open and hold phases, so d_out is stable before, during and after en_out is high.
- Reports completion with an ack pulse, and flags requests it drops.

Parameters:
WIDTH, 8, data word width (>=1)
SETUP_CYC, 2, cycles d_out is stable with en_out low before the window opens (>=1)
OPEN_CYC, 3, cycles en_out is held high (>=1)
HOLD_CYC, 2, cycles d_out is held with en_out low after the window closes (>=1)
CNT_W, 4, phase counter width; each *_CYC parameter must be < 2^CNT_W

Ports:
clk_in  input  1  clock; rising edge
rst_n_in  input  1  reset; asynchronous, active-low
req_in  input  1  capture request; sampled on rising edge
data_in  input  WIDTH  word to present to the latch; sampled together with an accepted req_in
d_out  output  WIDTH  data to the latch d_in; registered
en_out  output  1  latch enable to en_in; registered, glitch-free
busy_out  output  1  high while a sequence is in progress
ack_out  output  1  one-cycle pulse when a sequence completes
drop_out  output  1  one-cycle pulse when a request is ignored

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - state=IDLE, counter=0.
  - d_out=0, en_out=0, busy_out=0, ack_out=0, drop_out=0.
  - Applies immediately, mid-sequence included; en_out must fall without waiting for a clock edge.
- All outputs come straight from flops; no combinational path from any input to any output.
- States: IDLE, SETUP, OPEN, HOLD, DONE.
- IDLE:
  - en_out=0, busy_out=0.
  - If req_in=1 at an edge: load d_out<=data_in, busy_out<=1, counter<=SETUP_CYC-1, go to SETUP.
- SETUP:
  - en_out=0, d_out frozen.
  - When counter==0: counter<=OPEN_CYC-1, en_out<=1, go to OPEN. Otherwise decrement.
- OPEN:
  - en_out=1 for exactly OPEN_CYC cycles.
  - When counter==0: en_out<=0, counter<=HOLD_CYC-1, go to HOLD. Otherwise decrement.
- HOLD:
  - en_out=0, d_out frozen.
  - When counter==0: ack_out<=1, go to DONE. Otherwise decrement.
- DONE:
  - Lasts one cycle; ack_out=1, busy_out=1.
  - If req_in=1 at this edge: accept it as in IDLE (back-to-back, busy_out stays 1, new SETUP).
  - Otherwise: busy_out<=0, go to IDLE.
- Timing with req accepted at edge k, S=SETUP_CYC, O=OPEN_CYC, H=HOLD_CYC:
  - en_out is 1 after edges k+S through k+S+O-1.
  - ack_out is 1 after edge k+S+O+H, for one cycle.
  - busy_out falls after edge k+S+O+H+1 unless a back-to-back request is accepted.
- Dropped requests:
  - req_in=1 in SETUP, OPEN or HOLD is ignored and has no effect on the state, counter or d_out.
  - drop_out<=1 for one cycle on the next edge.
  - No queuing.
- d_out keeps its last value after the sequence ends, until the next accepted request. It does not return to 0.
- en_out is never high in the same cycle that d_out changes. d_out changes only on the IDLE/DONE-to-SETUP transition, while en_out=0.
- Counter does not wrap; the legal parameter range guarantees this.

Test Plan:
1. Reset, then req_in=1 for one cycle at edge 10 with data_in=8'hA5 and defaults -> d_out=A5 after edge 10; en_out high after edges 12,13,14 and low after edge 15; ack_out pulse after edge 17; busy_out low after edge 18.
2. Sequence as in 1, plus req_in=1 with data_in=8'h3C at edge 13 -> drop_out pulse after edge 14; d_out stays A5; timing is unchanged.
3. Sequence as in 1, plus req_in=1 with data_in=8'h5A at the DONE edge 18 -> ack_out pulse after edge 17, d_out=5A after edge 18, busy_out never drops, en_out high after edges 20..22.
4. Drive rst_n_in low halfway through a clock cycle while en_out=1 -> en_out, d_out and busy_out go to 0 immediately. After release, req_in=1 restarts cleanly with the full SETUP phase.
5. Override SETUP_CYC=1, OPEN_CYC=1, HOLD_CYC=1, request at edge k -> en_out high only after edge k+1; ack_out pulse after edge k+3.
6. Connect d_out/en_out to a d_latch_pls instance, run random req_in/data_in for 300 cycles -> latch q_out equals the last accepted data_in once each ack_out pulse occurs; no en_out high cycle coincides with a d_out change.
